fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of mem_access. Owns the program counter and drives
//  the mem_access bus request (pc, pc_data, en, w_rd). Buffers fetched opcode/operand bytes in a
//  DEPTH-entry prefetch FIFO, each tagged with its address, and hands them to the decoder over a
//  valid/ready handshake. The execute stage can take the bus (ex_req) and stall fetch at any time.
// PARAMETERS
//  DEPTH     4        prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  16'h0000 PC after reset when vector fetch is compiled out
// PORTS
//  clk_1     in   1   clock; all state updates on posedge
//  rst       in   1   asynchronous, active-low reset
//  pc        out  16  fetch address to mem_access (pc input)
//  pc_data   out  1   1 = mem_access selects pc; 0 = selects execute address (ex_req cycles)
//  en        out  1   bus cycle enable to mem_access
//  w_rd      out  1   0 = read; equals ex_w_rd while ex_req, else 0
//  data_in   in   8   read data returned from bus; valid at posedge ending an en=1 read cycle
//  ex_req    in   1   execute stage requests the bus this cycle (priority over fetch)
//  ex_w_rd   in   1   execute stage direction, passed to w_rd while ex_req=1
//  jmp       in   1   redirect: load PC from jmp_addr and flush FIFO
//  jmp_addr  in   16  redirect target
//  op_valid  out  1   FIFO head valid
//  op_byte   out  8   FIFO head byte
//  op_pc     out  16  address the head byte was fetched from
//  op_ready  in   1   decoder accepts head when op_valid && op_ready
//  fill      out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - rst low (async): pc_reg=RESET_PC (0xFFFC with vector fetch), FIFO empty, fill=0, op_valid=0,
//    op_byte=0, op_pc=0; en=0, pc_data=1, w_rd=0 while rst low. Mid-operation reset drops all data.
//  - States: S_VEC_LO, S_VEC_HI, S_RUN. Reset state S_VEC_LO if vector fetch built in, else S_RUN.
//  - Bus arbitration (combinational): ex_req=1 -> en=1, pc_data=0, w_rd=ex_w_rd, no fetch, PC held.
//    Else fetch issued when state=S_RUN && !jmp && fill<DEPTH -> en=1, pc_data=1, w_rd=0.
//    Else en=0, pc_data=1, w_rd=0. No lookahead: full FIFO with pop this cycle does not fetch.
//  - Fetch latency: single cycle; data_in captured at the posedge ending the request cycle and
//    pushed with tag pc; pc_reg increments by 1, 16-bit wrap 0xFFFF -> 0x0000.
//  - FIFO: push and pop same cycle -> fill unchanged; pop on empty ignored; push never when full.
//    op_valid/op_byte/op_pc are registered FIFO head outputs, no combinational input->output path.
//  - jmp=1 (S_RUN only): that posedge FIFO flushed (fill=0), pc_reg=jmp_addr, no fetch that cycle;
//    a simultaneous pop is discarded (flush wins). ex_req still honoured in the same cycle.
//    jmp while ex_req=1 still redirects. jmp in S_VEC_* ignored.
//  - pc output = pc_reg in S_RUN; vector address in S_VEC_*.
// CONFIGURATION
//  VECTOR_FETCH_EN defined: after reset S_VEC_LO reads 0xFFFC -> lo, S_VEC_HI reads 0xFFFD -> hi,
//    then pc_reg={hi,lo}, enter S_RUN. Each vector read stalls while ex_req=1; nothing pushed to FIFO.
//  VECTOR_FETCH_EN undefined: states S_VEC_* absent; S_RUN at RESET_PC from first cycle.
// TESTING
//  1 release rst, mem[i]=i, op_ready=0 -> fetches 0x0000..0x0003, fill=4, then en=0; head op_byte=0x00, op_pc=0x0000.
//  2 op_ready=1 continuously -> one byte/cycle, op_pc 0,1,2,... contiguous, fill steady, no duplicates/drops.
//  3 ex_req=1 for 3 cycles, ex_w_rd=1 -> en=1, pc_data=0, w_rd=1 each cycle; pc and fill frozen (no pop).
//  4 fill=3, jmp=1 jmp_addr=0x1234 with op_ready=1 -> next cycle fill=0, op_valid=0; next head op_pc=0x1234.
//  5 jmp to 0xFFFF -> fetches at 0xFFFF then 0x0000; op_pc shows wrap; rst pulsed mid-stream -> fill=0 at once.
//  6 VECTOR_FETCH_EN, mem[FFFC]=0x00, mem[FFFD]=0x80 -> reads FFFC, FFFD, first FIFO byte tagged op_pc=0x8000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, shares the mem_access bus with execute and buffers
// address-tagged bytes in a prefetch FIFO. Define VECTOR_FETCH_EN to load the PC from 0xFFFC/D.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk_1,
    input  logic                   rst,
    output logic [15:0]            pc,
    output logic                   pc_data,
    output logic                   en,
    output logic                   w_rd,
    input  logic [7:0]             data_in,
    input  logic                   ex_req,
    input  logic                   ex_w_rd,
    input  logic                   jmp,
    input  logic [15:0]            jmp_addr,
    output logic                   op_valid,
    output logic [7:0]             op_byte,
    output logic [15:0]            op_pc,
    input  logic                   op_ready,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

`ifdef VECTOR_FETCH_EN
    localparam logic [15:0] ResetPc = 16'hfffc;

    typedef enum logic [1:0] {StVecLo, StVecHi, StRun} state_e;

    state_e     state_q;
    logic [7:0] vec_lo_q;
`else
    localparam logic [15:0] ResetPc = RESET_PC;
`endif

    logic [15:0]   pc_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;
    logic [AW:0]   fill_d;
    logic [7:0]    byte_q [DEPTH];
    logic [15:0]   tag_q  [DEPTH];
    logic          run;
    logic          vec_rd;
    logic          fetch;
    logic          pop;

    always_comb begin
        run    = 1'b1;
        vec_rd = 1'b0;
        pc     = pc_q;
`ifdef VECTOR_FETCH_EN
        run    = (state_q == StRun);
        vec_rd = !run && !ex_req;
        if (!run) pc = {15'h7ffe, state_q == StVecHi};
`endif
        // No lookahead: a pop from a full FIFO does not free a slot this cycle.
        fetch = run && !jmp && !ex_req && (fill_q != FullCnt);
        pop   = (fill_q != '0) && op_ready;

        case ({fetch, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        en      = 1'b0;
        pc_data = 1'b1;
        w_rd    = 1'b0;
        if (rst) begin
            if (ex_req) begin
                en      = 1'b1;
                pc_data = 1'b0;
                w_rd    = ex_w_rd;
            end else if (fetch || vec_rd) begin
                en = 1'b1;
            end
        end
    end

    assign op_valid = (fill_q != '0);
    assign op_byte  = byte_q[rd_ptr_q];
    assign op_pc    = tag_q[rd_ptr_q];
    assign fill     = fill_q;

    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            pc_q     <= ResetPc;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                byte_q[i] <= '0;
                tag_q[i]  <= '0;
            end
`ifdef VECTOR_FETCH_EN
            state_q  <= StVecLo;
            vec_lo_q <= '0;
`endif
        end else begin
            if (run && jmp) begin
                // Flush wins over any pop presented in the same cycle.
                pc_q     <= jmp_addr;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                fill_q   <= '0;
            end else begin
                if (fetch) begin
                    byte_q[wr_ptr_q] <= data_in;
                    tag_q[wr_ptr_q]  <= pc_q;
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                    pc_q             <= pc_q + 16'd1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                fill_q <= fill_d;
            end
`ifdef VECTOR_FETCH_EN
            case (state_q)
                StVecLo: begin
                    if (!ex_req) begin
                        vec_lo_q <= data_in;
                        state_q  <= StVecHi;
                    end
                end
                StVecHi: begin
                    if (!ex_req) begin
                        pc_q    <= {data_in, vec_lo_q};
                        state_q <= StRun;
                    end
                end
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus hand-computed
// literal expectations for the directed scenarios.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk_1;
    logic        rst;
    logic [15:0] pc;
    logic        pc_data;
    logic        en;
    logic        w_rd;
    logic [7:0]  data_in;
    logic        ex_req;
    logic        ex_w_rd;
    logic        jmp;
    logic [15:0] jmp_addr;
    logic        op_valid;
    logic [7:0]  op_byte;
    logic [15:0] op_pc;
    logic        op_ready;
    logic [2:0]  fill;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_1    (clk_1),
        .rst      (rst),
        .pc       (pc),
        .pc_data  (pc_data),
        .en       (en),
        .w_rd     (w_rd),
        .data_in  (data_in),
        .ex_req   (ex_req),
        .ex_w_rd  (ex_w_rd),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .op_valid (op_valid),
        .op_byte  (op_byte),
        .op_pc    (op_pc),
        .op_ready (op_ready),
        .fill     (fill)
    );

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    // Memory image: mem[i] = low byte of i, except the reset vector reads 0x8000.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'hfffc) return 8'h00;
        if (a == 16'hfffd) return 8'h80;
        return a[7:0];
    endfunction

    always_comb data_in = mem_byte(pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {byte, tag}; m_st 0 = running, 1/2 = vector lo/hi read.
    logic [23:0] mq[$];
    logic [15:0] m_pc = RST_PC;
    int          m_st = 0;
    logic [7:0]  m_lo = 8'h00;

    always @(posedge clk_1 or negedge rst) begin
        bit do_pop;
        bit do_fetch;
        if (!rst) begin
            mq.delete();
            m_lo <= 8'h00;
`ifdef VECTOR_FETCH_EN
            m_pc <= 16'hfffc;
            m_st <= 1;
`else
            m_pc <= RST_PC;
            m_st <= 0;
`endif
        end else if (m_st == 0) begin
            if (jmp) begin
                mq.delete();
                m_pc <= jmp_addr;
            end else begin
                do_pop   = op_ready && (mq.size() > 0);
                do_fetch = !ex_req && (mq.size() < DEPTH);
                if (do_pop) void'(mq.pop_front());
                if (do_fetch) begin
                    mq.push_back({mem_byte(m_pc), m_pc});
                    m_pc <= m_pc + 16'd1;
                end
            end
        end else if (!ex_req) begin
            if (m_st == 1) begin
                m_lo <= mem_byte(16'hfffc);
                m_st <= 2;
            end else begin
                m_pc <= {mem_byte(16'hfffd), m_lo};
                m_st <= 0;
            end
        end
    end

    // Compare process: late in the low phase, after all input changes have settled.
    always @(negedge clk_1) begin
        logic       e_en;
        logic       e_pd;
        logic       e_wr;
        logic [15:0] e_pc;
        #4;
        e_pc = (m_st == 0) ? m_pc : ((m_st == 1) ? 16'hfffc : 16'hfffd);
        e_en = 1'b0;
        e_pd = 1'b1;
        e_wr = 1'b0;
        if (rst) begin
            if (ex_req) begin
                e_en = 1'b1;
                e_pd = 1'b0;
                e_wr = ex_w_rd;
            end else if (m_st != 0 || (!jmp && mq.size() < DEPTH)) begin
                e_en = 1'b1;
            end
        end
        chk("en", en, e_en);
        chk("pc_data", pc_data, e_pd);
        chk("w_rd", w_rd, e_wr);
        chk("pc", pc, e_pc);
        chk("fill", fill, mq.size());
        chk("op_valid", op_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("op_byte", op_byte, mq[0][23:16]);
            chk("op_pc", op_pc, mq[0][15:0]);
        end else if (!rst) begin
            chk("op_byte_rst", op_byte, 8'h00);
            chk("op_pc_rst", op_pc, 16'h0000);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1);
    endtask

    initial begin
        rst      = 1'b0;
        ex_req   = 1'b0;
        ex_w_rd  = 1'b0;
        jmp      = 1'b0;
        jmp_addr = 16'h0000;
        op_ready = 1'b0;
        tick(3);
        #2;
        chk("rst_fill", fill, 0);
        chk("rst_en", en, 0);
        chk("rst_op_valid", op_valid, 0);
        rst = 1'b1;

`ifdef VECTOR_FETCH_EN
        #2;
        chk("vec_lo_pc", pc, 16'hfffc);
        chk("vec_lo_en", en, 1);
        tick(3);
        #2;
        chk("vec_first_fill", fill, 1);
        chk("vec_first_op_pc", op_pc, 16'h8000);
        chk("vec_first_byte", op_byte, 8'h00);
`else
        // Fill the FIFO with no consumer.
        tick(6);
        #2;
        chk("t1_fill", fill, 4);
        chk("t1_en", en, 0);
        chk("t1_op_byte", op_byte, 8'h00);
        chk("t1_op_pc", op_pc, 16'h0000);
        chk("t1_pc", pc, 16'h0004);
        op_ready = 1'b1;

        // Streaming: full FIFO pops without refilling, then settles at 3.
        tick(4);
        #2;
        chk("t2_op_pc", op_pc, 16'h0004);
        chk("t2_fill", fill, 3);
        chk("t2_pc", pc, 16'h0007);
        op_ready = 1'b0;
        ex_req   = 1'b1;
        ex_w_rd  = 1'b1;
        #1;
        chk("t3_en", en, 1);
        chk("t3_pc_data", pc_data, 0);
        chk("t3_w_rd", w_rd, 1);

        // Execute owns the bus: PC and FIFO frozen.
        tick(3);
        #2;
        chk("t3_pc_hold", pc, 16'h0007);
        chk("t3_fill_hold", fill, 3);
        #1;
        ex_req   = 1'b0;
        ex_w_rd  = 1'b0;
        jmp      = 1'b1;
        jmp_addr = 16'h1234;
        op_ready = 1'b1;

        // Redirect with a simultaneous pop: flush wins.
        tick(1);
        jmp      = 1'b0;
        op_ready = 1'b0;
        #2;
        chk("t4_fill", fill, 0);
        chk("t4_op_valid", op_valid, 0);
        chk("t4_pc", pc, 16'h1234);
        tick(1);
        #2;
        chk("t4_head_pc", op_pc, 16'h1234);
        chk("t4_head_byte", op_byte, 8'h34);
        jmp      = 1'b1;
        jmp_addr = 16'hffff;
        ex_req   = 1'b1;

        // Redirect during an execute cycle, then fetch across the 16-bit wrap.
        tick(1);
        jmp    = 1'b0;
        ex_req = 1'b0;
        tick(3);
        #2;
        chk("t5_fill", fill, 3);
        chk("t5_op_pc", op_pc, 16'hffff);
        chk("t5_op_byte", op_byte, 8'hff);
        chk("t5_pc_wrap", pc, 16'h0002);
        op_ready = 1'b1;
        tick(1);
        #2;
        chk("t5_op_pc_wrap", op_pc, 16'h0000);
        chk("t5_fill_steady", fill, 3);
        rst = 1'b0;
        #1;
        chk("t5_rst_fill", fill, 0);
        chk("t5_rst_valid", op_valid, 0);
        chk("t5_rst_en", en, 0);
        chk("t5_rst_pc", pc, RST_PC);
        tick(2);
        rst      = 1'b1;
        op_ready = 1'b0;
`endif

        // Mixed traffic, checked by the model every cycle.
        for (int i = 0; i < 40; i++) begin
            tick(1);
            ex_req   = (i % 5) == 2;
            ex_w_rd  = (i % 2) == 0;
            op_ready = (i % 3) != 0;
            jmp      = (i == 17) || (i == 29);
            jmp_addr = (i == 17) ? 16'h00f0 : 16'hfffe;
        end
        tick(1);
        ex_req   = 1'b0;
        jmp      = 1'b0;
        op_ready = 1'b0;
        tick(2);
        #5;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
